// File: rtl/serial_alu_nbit_pkg.sv
// serial_alu_pkg: opcodes, FSM state type and the subtract-class helper shared by the serial ALU files
package serial_alu_pkg;
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  function automatic logic is_sub(input logic [2:0] op);
    return op == OP_SUB || op == OP_SLT;
  endfunction
endpackage

// File: rtl/serial_alu_nbit_if.sv
// serial_alu_nbit_if: operand side (in_valid/in_ready/op/a/b) and result side (out_valid/out_ready/result/zero/carry/overflow); master drives operands, slave is the ALU
interface serial_alu_nbit_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;
  modport master (output in_valid, op, a, b, out_ready, input in_ready, out_valid, result, zero, carry, overflow);
  modport slave (input in_valid, op, a, b, out_ready, output in_ready, out_valid, result, zero, carry, overflow);
endinterface

// File: rtl/serial_alu_nbit_alu_bit_slice.sv
// alu_bit_slice: combinational 1-bit ALU slice (i_op, i_a_bit, i_b_bit, i_carry_in -> o_res_bit, o_carry_out); SLT only when SERIAL_ALU_SLT_EN is defined
module alu_bit_slice
  import serial_alu_pkg::*;
(
  input  logic [2:0] i_op,
  input  logic       i_a_bit,
  input  logic       i_b_bit,
  input  logic       i_carry_in,
  output logic       o_res_bit,
  output logic       o_carry_out
);
  logic w_b, w_sum, w_maj, w_slt, w_arith;
`ifdef SERIAL_ALU_SLT_EN
  assign w_slt = i_op == OP_SLT;
`else
  assign w_slt = 1'b0;
`endif
  assign w_arith = i_op == OP_ADD || i_op == OP_SUB || w_slt;
  assign w_b = is_sub(i_op) ? ~i_b_bit : i_b_bit;
  assign w_sum = i_a_bit ^ w_b ^ i_carry_in;
  assign w_maj = (i_a_bit & w_b) | (i_a_bit & i_carry_in) | (w_b & i_carry_in);
  assign o_res_bit = i_op == OP_AND ? i_a_bit & i_b_bit :
                     i_op == OP_OR  ? i_a_bit | i_b_bit :
                     i_op == OP_XOR ? i_a_bit ^ i_b_bit :
                     i_op == OP_NOR ? ~(i_a_bit | i_b_bit) :
                     w_arith        ? w_sum : 1'b0;
  assign o_carry_out = w_arith & w_maj;
endmodule

// File: rtl/serial_alu_nbit.sv
// serial_alu_nbit: WIDTH-bit bit-serial ALU (clk, rst, serial_alu_nbit_if.slave bus), LSB first, WIDTH cycles per op; SLT enabled by SERIAL_ALU_SLT_EN
module serial_alu_nbit
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  serial_alu_nbit_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_result;
  logic [WIDTH-2:0] r_sh;
  logic             r_c, r_zero, r_carry, r_ovf;
  logic             w_res_bit, w_cout, w_arith, w_ovf;
  logic [WIDTH-1:0] w_sh_next, w_final;
  alu_bit_slice u_slice (
    .i_op       (r_op),
    .i_a_bit    (r_a[0]),
    .i_b_bit    (r_b[0]),
    .i_carry_in (r_c),
    .o_res_bit  (w_res_bit),
    .o_carry_out(w_cout)
  );
  assign w_sh_next = {w_res_bit, r_sh};
  assign w_arith = r_op == OP_ADD || r_op == OP_SUB;
  assign w_ovf = r_c ^ w_cout;
`ifdef SERIAL_ALU_SLT_EN
  assign w_final = r_op == OP_SLT ? WIDTH'(w_res_bit ^ w_ovf) : w_sh_next;
`else
  assign w_final = w_sh_next;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.in_valid) begin
          r_a     <= bus.a;
          r_b     <= bus.b;
          r_op    <= bus.op;
          r_c     <= is_sub(bus.op);
          r_cnt   <= '0;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_sh  <= w_sh_next[WIDTH-1:1];
          r_c   <= w_cout;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_result <= w_final;
            r_zero   <= ~|w_final;
            r_carry  <= w_arith & w_cout;
            r_ovf    <= w_arith & w_ovf;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: if (bus.out_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  assign bus.in_ready  = r_state == ST_IDLE;
  assign bus.out_valid = r_state == ST_DONE;
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.carry     = r_carry;
  assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_serial_alu_nbit.sv
// tb_serial_alu_nbit: directed and random checks of serial_alu_nbit against an arithmetic reference model
module tb_serial_alu_nbit;
  import serial_alu_pkg::*;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_assert = 0;
  int n_fail = 0;
  serial_alu_nbit_if #(.WIDTH(W)) bus ();
  serial_alu_nbit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [W+2:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    logic [W-1:0] r;
    logic c, v;
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOR: r = ~(a | b);
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[W-1:0]; c = s[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      OP_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 1;
        r = s[W-1:0]; c = s[W];
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
`ifdef SERIAL_ALU_SLT_EN
      OP_SLT: r = ($signed(a) < $signed(b)) ? 1 : 0;
`endif
      default: r = '0;
    endcase
    return {v, c, r == 0, r};
  endfunction
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int stall, input string tag);
    logic [W+2:0] e;
    logic [W-1:0] held;
    int lat;
    e = model(op, a, b);
    bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    check({tag, ".in_ready_idle"}, bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom); bus.op = 3'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, lat, W);
    check({tag, ".result"}, bus.result, e[W-1:0]);
    check({tag, ".zero"}, bus.zero, e[W]);
    check({tag, ".carry"}, bus.carry, e[W+1]);
    check({tag, ".overflow"}, bus.overflow, e[W+2]);
    check({tag, ".in_ready_done"}, bus.in_ready, 0);
    held = bus.result;
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'b1; bus.a = W'($urandom); bus.b = W'($urandom); bus.op = 3'($urandom);
      @(posedge clk); #1;
      check({tag, ".stall_valid"}, bus.out_valid, 1);
      check({tag, ".stall_in_ready"}, bus.in_ready, 0);
      check({tag, ".stall_result"}, bus.result, held);
      check({tag, ".stall_flags"}, {bus.overflow, bus.carry, bus.zero}, e[W+2:W]);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    check({tag, ".post_out_valid"}, bus.out_valid, 0);
    check({tag, ".post_in_ready"}, bus.in_ready, 1);
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset.in_ready", bus.in_ready, 1);
    check("reset.out_valid", bus.out_valid, 0);
    check("reset.outputs", {bus.result, bus.zero, bus.carry, bus.overflow}, 0);
    run_op(OP_ADD, 8'h7F, 8'h01, 0, "add_ovf");
    run_op(OP_SUB, 8'h05, 8'h05, 0, "sub_eq");
    run_op(OP_AND, 8'hF0, 8'h0F, 0, "and_zero");
    run_op(OP_SLT, 8'hFD, 8'h02, 0, "slt_neg");
    run_op(OP_SLT, 8'h02, 8'hFD, 0, "slt_pos");
    run_op(OP_OR, 8'hA5, 8'h5A, 5, "backpressure");
    run_op(OP_RSVD, 8'hFF, 8'hFF, 0, "reserved");
    run_op(OP_SUB, 8'h80, 8'h01, 0, "sub_ovf");
    run_op(OP_XOR, 8'h3C, 8'hFF, 1, "xor");
    bus.op = OP_ADD; bus.a = 8'h11; bus.b = 8'h22; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrun_rst.out_valid", bus.out_valid, 0);
    check("midrun_rst.in_ready", bus.in_ready, 1);
    check("midrun_rst.outputs", {bus.result, bus.zero, bus.carry, bus.overflow}, 0);
    run_op(OP_ADD, 8'h10, 8'h20, 0, "after_rst");
    for (int k = 0; k < 40; k++)
      run_op(3'($urandom), W'($urandom), W'($urandom), int'($urandom_range(0, 2)), "random");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_alu_nbit.md
Name: serial_alu_nbit

Overview:
- Parametrised successor to the team's 1-bit combinational ALU.
- Performs WIDTH-bit ALU operations bit-serially: one 1-bit slice per clock, LSB first, with a carry register between steps.
- Valid/ready on both the operand and result sides.
- Sits behind the project top-level pin wrapper; trades latency for area on small tiles.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit counter width; derived, not overridden.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and opcode valid.
- in_ready  out  1  block can accept; high only in IDLE.
- op  in  3  opcode: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 NOR, 110 SLT, 111 reserved.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result and flags valid; high only in DONE.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  operation result.
- zero  out  1  result == 0.
- carry  out  1  carry-out of MSB for ADD/SUB (SUB: 1 = no borrow); 0 otherwise.
- overflow  out  1  signed overflow for ADD/SUB; 0 otherwise.

Behaviour:
- Reset behaviour:
  - rst high at an edge forces IDLE, counter 0, and result/zero/carry/overflow/out_valid to 0.
  - Takes priority over every other event.
  - Mid-RUN or mid-DONE, the operation in flight is discarded with no partial output.
- States: IDLE, RUN, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- IDLE:
  - On in_valid && in_ready, load a/b into shift registers and latch op.
  - Carry register initialises to 1 for SUB/SLT, else 0. Clear the counter.
  - Go to RUN.
- RUN, each cycle:
  - Slice computes the bit from a_sh[0], b_sh[0] (b inverted for SUB/SLT) and the carry register.
  - result_sh <= {bit, result_sh[WIDTH-1:1]}; a_sh and b_sh shift right; carry register updates; counter increments.
  - At counter==WIDTH-1:
    - carry = slice carry-out.
    - overflow = slice carry-in XOR carry-out, ADD/SUB only.
    - Go to DONE.
- Latency: exactly WIDTH rising edges from the accept edge to out_valid high.
- SLT:
  - Subtraction runs serially.
  - On entering DONE, result = {0…, sign_bit XOR overflow}.
  - carry and overflow report 0.
- Logical ops (AND, OR, XOR, NOR): carry = overflow = 0.
- Reserved op 111: result 0, zero 1, carry/overflow 0, same latency.
- zero = ~|result, valid whenever out_valid is high.
- DONE:
  - result and flags held stable while out_valid && !out_ready.
  - On out_ready, go to IDLE.
- Handshake rules:
  - in_valid is ignored outside IDLE, so no accept occurs in the cycle of the result handshake.
  - Throughput: one operation per WIDTH+2 cycles minimum.
  - Inputs a, b, op are sampled only on the accept edge; later changes have no effect.
- Arithmetic is modulo 2^WIDTH; no saturation.

Optional Feature:
- Macro: SERIAL_ALU_SLT_EN.
- Defined: op 110 performs SLT as above.
- Undefined: op 110 behaves exactly as reserved (result 0, zero 1); SLT override logic not synthesised.

Decomposition:
- Shared package serial_alu_pkg:
  - Opcode localparams (OP_AND … OP_RSVD).
  - State enum (ST_IDLE, ST_RUN, ST_DONE).
  - Helper function is_sub(op) (true for SUB/SLT).
- One natural sub-module, alu_bit_slice: combinational 1-bit slice.
  - Inputs: op, a_bit, b_bit, carry_in.
  - Outputs: res_bit, carry_out.
  - Instantiated once and reused every RUN cycle.

Test Plan (WIDTH=8):
- ADD a=0x7F b=0x01 -> out_valid exactly 8 edges after accept; result 0x80, zero 0, carry 0, overflow 1.
- SUB a=0x05 b=0x05 -> result 0x00, zero 1, carry 1, overflow 0; AND a=0xF0 b=0x0F -> result 0x00, zero 1, carry 0.
- SLT a=0xFD (-3) b=0x02 with SERIAL_ALU_SLT_EN -> result 0x01; same stimulus without the macro -> result 0x00, zero 1.
- Backpressure: out_ready low 5 cycles after out_valid -> result/flags stable, in_ready 0, concurrent in_valid with new operands ignored; out_ready high -> IDLE next edge, in_ready 1.
- Reset asserted at RUN counter==3 -> next edge out_valid 0, in_ready 1, outputs 0; following ADD 0x10+0x20 -> 0x30 with no corruption.
- Reserved op 111 a=0xFF b=0xFF -> result 0x00, zero 1, carry 0, overflow 0, latency 8.
